// File: rtl/alu_exec_stage.sv
// ============================================================================
// Module   : alu_exec_stage
// Brief    : Two-stage execute wrapper around an external combinational ALU.
//            Operand register (S1) drives the ALU, result register (S2)
//            captures it; architectural C/Z/N flags supply the carry-in.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_exec_stage #(
    parameter int BUS_WIDTH    = 8,
    parameter int OPCODE_WIDTH = 5,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPCODE_WIDTH-1:0] in_opcode,
    input  logic [BUS_WIDTH-1:0]    in_a,
    input  logic [BUS_WIDTH-1:0]    in_b,
    input  logic                    in_use_carry,
    input  logic                    in_flags_we,

    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    output logic [BUS_WIDTH-1:0]    alu_a,
    output logic [BUS_WIDTH-1:0]    alu_b,
    output logic                    alu_cin,
    input  logic [BUS_WIDTH-1:0]    alu_y,
    input  logic                    alu_cout,
    input  logic                    alu_zero,
    input  logic                    alu_negative,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BUS_WIDTH-1:0]    out_y,
    output logic                    out_cout,
    output logic                    out_zero,
    output logic                    out_negative,

    output logic                    flag_c,
    output logic                    flag_z,
    output logic                    flag_n,
    output logic [CNT_WIDTH-1:0]    ops_retired
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Stage 1: operand register
    logic                    v1_q,           v1_d;
    logic [OPCODE_WIDTH-1:0] s1_opcode_q,    s1_opcode_d;
    logic [BUS_WIDTH-1:0]    s1_a_q,         s1_a_d;
    logic [BUS_WIDTH-1:0]    s1_b_q,         s1_b_d;
    logic                    s1_use_carry_q, s1_use_carry_d;
    logic                    s1_flags_we_q,  s1_flags_we_d;

    // Stage 2: result register
    logic                    out_valid_q,    out_valid_d;
    logic [BUS_WIDTH-1:0]    out_y_q,        out_y_d;
    logic                    out_cout_q,     out_cout_d;
    logic                    out_zero_q,     out_zero_d;
    logic                    out_negative_q, out_negative_d;

    // Architectural status and retire counter
    logic                    flag_c_q,       flag_c_d;
    logic                    flag_z_q,       flag_z_d;
    logic                    flag_n_q,       flag_n_d;
    logic [CNT_WIDTH-1:0]    ops_retired_q,  ops_retired_d;

    logic w_adv2;
    logic w_accept;
    logic w_retire;
    logic w_in_ready;

    // in_ready looks through to out_ready so a full pipe can shift and refill
    // on the same edge.
    always_comb begin
        w_adv2     = v1_q & (~out_valid_q | out_ready);
        w_in_ready = ~rst & (~v1_q | w_adv2);
        w_accept   = in_valid & w_in_ready;
        w_retire   = out_valid_q & out_ready;
    end

    always_comb begin
        v1_d           = v1_q & ~w_adv2;
        s1_opcode_d    = s1_opcode_q;
        s1_a_d         = s1_a_q;
        s1_b_d         = s1_b_q;
        s1_use_carry_d = s1_use_carry_q;
        s1_flags_we_d  = s1_flags_we_q;
        if (w_accept) begin
            v1_d           = 1'b1;
            s1_opcode_d    = in_opcode;
            s1_a_d         = in_a;
            s1_b_d         = in_b;
            s1_use_carry_d = in_use_carry;
            s1_flags_we_d  = in_flags_we;
        end
    end

    always_comb begin
        out_valid_d    = out_valid_q;
        out_y_d        = out_y_q;
        out_cout_d     = out_cout_q;
        out_zero_d     = out_zero_q;
        out_negative_d = out_negative_q;
        flag_c_d       = flag_c_q;
        flag_z_d       = flag_z_q;
        flag_n_d       = flag_n_q;
        ops_retired_d  = ops_retired_q;

        if (w_adv2) begin
            out_valid_d    = 1'b1;
            out_y_d        = alu_y;
            out_cout_d     = alu_cout;
            out_zero_d     = alu_zero;
            out_negative_d = alu_negative;
            if (s1_flags_we_q) begin
                flag_c_d = alu_cout;
                flag_z_d = alu_zero;
                flag_n_d = alu_negative;
            end
        end else if (w_retire) begin
            out_valid_d = 1'b0;
        end

        if (w_retire) begin
            ops_retired_d = ops_retired_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q           <= 1'b0;
            s1_opcode_q    <= '0;
            s1_a_q         <= '0;
            s1_b_q         <= '0;
            s1_use_carry_q <= 1'b0;
            s1_flags_we_q  <= 1'b0;
            out_valid_q    <= 1'b0;
            out_y_q        <= '0;
            out_cout_q     <= 1'b0;
            out_zero_q     <= 1'b0;
            out_negative_q <= 1'b0;
            flag_c_q       <= 1'b0;
            flag_z_q       <= 1'b0;
            flag_n_q       <= 1'b0;
            ops_retired_q  <= '0;
        end else begin
            v1_q           <= v1_d;
            s1_opcode_q    <= s1_opcode_d;
            s1_a_q         <= s1_a_d;
            s1_b_q         <= s1_b_d;
            s1_use_carry_q <= s1_use_carry_d;
            s1_flags_we_q  <= s1_flags_we_d;
            out_valid_q    <= out_valid_d;
            out_y_q        <= out_y_d;
            out_cout_q     <= out_cout_d;
            out_zero_q     <= out_zero_d;
            out_negative_q <= out_negative_d;
            flag_c_q       <= flag_c_d;
            flag_z_q       <= flag_z_d;
            flag_n_q       <= flag_n_d;
            ops_retired_q  <= ops_retired_d;
        end
    end

    // Flags only change when S1 drains, so alu_cin is stable under backpressure.
    assign alu_cin      = s1_use_carry_q & flag_c_q;
    assign alu_opcode   = s1_opcode_q;
    assign alu_a        = s1_a_q;
    assign alu_b        = s1_b_q;

    assign in_ready     = w_in_ready;
    assign out_valid    = out_valid_q;
    assign out_y        = out_y_q;
    assign out_cout     = out_cout_q;
    assign out_zero     = out_zero_q;
    assign out_negative = out_negative_q;
    assign flag_c       = flag_c_q;
    assign flag_z       = flag_z_q;
    assign flag_n       = flag_n_q;
    assign ops_retired  = ops_retired_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
// ============================================================================
// Module   : tb_alu_exec_stage
// Brief    : Directed bench for alu_exec_stage with an adder standing in for
//            the external ALU (y = a + b + cin).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_exec_stage;

    localparam int BUS_WIDTH    = 8;
    localparam int OPCODE_WIDTH = 5;
    localparam int CNT_WIDTH    = 16;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [OPCODE_WIDTH-1:0] in_opcode;
    logic [BUS_WIDTH-1:0]    in_a;
    logic [BUS_WIDTH-1:0]    in_b;
    logic                    in_use_carry;
    logic                    in_flags_we;
    logic [OPCODE_WIDTH-1:0] alu_opcode;
    logic [BUS_WIDTH-1:0]    alu_a;
    logic [BUS_WIDTH-1:0]    alu_b;
    logic                    alu_cin;
    logic [BUS_WIDTH-1:0]    alu_y;
    logic                    alu_cout;
    logic                    alu_zero;
    logic                    alu_negative;
    logic                    out_valid;
    logic                    out_ready;
    logic [BUS_WIDTH-1:0]    out_y;
    logic                    out_cout;
    logic                    out_zero;
    logic                    out_negative;
    logic                    flag_c;
    logic                    flag_z;
    logic                    flag_n;
    logic [CNT_WIDTH-1:0]    ops_retired;

    int errors = 0;
    int checks = 0;

    alu_exec_stage #(
        .BUS_WIDTH    (BUS_WIDTH),
        .OPCODE_WIDTH (OPCODE_WIDTH),
        .CNT_WIDTH    (CNT_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_use_carry (in_use_carry),
        .in_flags_we  (in_flags_we),
        .alu_opcode   (alu_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cin      (alu_cin),
        .alu_y        (alu_y),
        .alu_cout     (alu_cout),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_cout     (out_cout),
        .out_zero     (out_zero),
        .out_negative (out_negative),
        .flag_c       (flag_c),
        .flag_z       (flag_z),
        .flag_n       (flag_n),
        .ops_retired  (ops_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: 8-bit add with carry in/out
    logic [BUS_WIDTH:0] alu_sum;
    always_comb begin
        alu_sum      = {1'b0, alu_a} + {1'b0, alu_b} + {{BUS_WIDTH{1'b0}}, alu_cin};
        alu_y        = alu_sum[BUS_WIDTH-1:0];
        alu_cout     = alu_sum[BUS_WIDTH];
        alu_zero     = (alu_sum[BUS_WIDTH-1:0] == '0);
        alu_negative = alu_sum[BUS_WIDTH-1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic uc, input logic fwe);
        in_valid     = v;
        in_a         = a;
        in_b         = b;
        in_use_carry = uc;
        in_flags_we  = fwe;
        in_opcode    = 5'b00_001;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Reset and idle
        tick();
        tick();
        check("rst_in_ready",    in_ready, 0);
        check("rst_out_valid",   out_valid, 0);
        check("rst_out_y",       out_y, 0);
        check("rst_flags",       {flag_c, flag_z, flag_n}, 0);
        check("rst_ops_retired", ops_retired, 0);
        check("rst_alu_a",       alu_a, 0);
        check("rst_alu_cin",     alu_cin, 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready",   in_ready, 1);

        // Single op: 0x0F + 0x01 = 0x10
        out_ready = 1'b1;
        drive(1'b1, 8'h0F, 8'h01, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("single_alu_a",    alu_a, 8'h0F);
        check("single_alu_b",    alu_b, 8'h01);
        check("single_opcode",   alu_opcode, 5'b00_001);
        check("single_s1_valid", out_valid, 0);
        tick();
        check("single_out_valid", out_valid, 1);
        check("single_out_y",     out_y, 8'h10);
        check("single_out_cout",  out_cout, 0);
        check("single_flag_z",    flag_z, 0);
        tick();
        check("single_retired",   ops_retired, 1);
        check("single_drained",   out_valid, 0);

        // Carry chain: 0xFF + 0x01 sets C and Z, next op consumes carry
        drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'h00, 8'h00, 1'b1, 1'b1);
        #1;
        check("chain_in_ready",  in_ready, 1);
        check("chain_cin_op1",   alu_cin, 0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("chain_cin_op2",   alu_cin, 1);
        check("chain_flag_c",    flag_c, 1);
        check("chain_flag_z",    flag_z, 1);
        check("chain_op1_y",     out_y, 8'h00);
        check("chain_op1_cz",    {out_cout, out_zero}, 2'b11);
        tick();
        check("chain_op2_y",     out_y, 8'h01);
        check("chain_op2_flags", {flag_c, flag_z, flag_n}, 3'b000);
        check("chain_retired",   ops_retired, 2);
        tick();
        check("chain_retired2",  ops_retired, 3);

        // flags_we = 0: result carry visible, status register untouched
        drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        check("nofl_out_cout",   out_cout, 1);
        check("nofl_out_zero",   out_zero, 1);
        check("nofl_flag_c",     flag_c, 0);
        check("nofl_flag_z",     flag_z, 0);
        tick();
        check("nofl_retired",    ops_retired, 4);

        // Backpressure: A, B buffered, C refused until out_ready returns
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 8'h02, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'h10, 8'h20, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'h05, 8'h05, 1'b0, 1'b1);
        #1;
        check("bp_full_in_ready", in_ready, 0);
        check("bp_a_result",      out_y, 8'h03);
        check("bp_hold_alu_a",    alu_a, 8'h10);
        tick();
        check("bp_stable_alu_a",  alu_a, 8'h10);
        check("bp_stable_alu_b",  alu_b, 8'h20);
        check("bp_stable_out_y",  out_y, 8'h03);
        check("bp_no_retire",     ops_retired, 4);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("bp_b_result",      out_y, 8'h30);
        check("bp_c_in_s1",       alu_a, 8'h05);
        check("bp_retired_a",     ops_retired, 5);
        tick();
        check("bp_c_result",      out_y, 8'h0A);
        check("bp_retired_b",     ops_retired, 6);
        tick();
        check("bp_retired_c",     ops_retired, 7);
        check("bp_drained",       out_valid, 0);

        // Reset with two ops in flight
        out_ready = 1'b0;
        drive(1'b1, 8'h80, 8'h00, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'h01, 8'h01, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("mid_pre_flag_n",   flag_n, 1);
        check("mid_pre_valid",    out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_out_valid",    out_valid, 0);
        check("mid_flags",        {flag_c, flag_z, flag_n}, 0);
        check("mid_retired",      ops_retired, 0);
        check("mid_alu_a",        alu_a, 0);
        out_ready = 1'b1;
        tick();
        tick();
        check("mid_no_result",    out_valid, 0);
        check("mid_no_retire",    ops_retired, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_exec_stage.md
# alu_exec_stage

Two-stage pipelined execute wrapper that feeds operands to the combinational ALU decoder and captures its result. It accepts one operation per cycle from issue logic over a valid/ready handshake and registers the operands. It drives the ALU with a carry-in taken from an architectural status register, then registers the result and flags for writeback over a second valid/ready handshake. The ALU stays external; this block connects to it through the alu_* ports.

## Interface
- BUS_WIDTH, 8, data width of operands and result
- OPCODE_WIDTH, 5, ALU opcode width (2-bit class prefix + 3-bit inst)
- CNT_WIDTH, 16, width of retired-operation counter

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  issue offers an operation
- in_ready  out  1  stage 1 can accept this cycle
- in_opcode  in  OPCODE_WIDTH  ALU opcode
- in_a, in_b  in  BUS_WIDTH  operands
- in_use_carry  in  1  1: alu_cin = flag_c; 0: alu_cin = 0
- in_flags_we  in  1  1: operation updates flag_c/z/n
- alu_opcode  out  OPCODE_WIDTH  registered opcode to ALU
- alu_a, alu_b  out  BUS_WIDTH  registered operands to ALU
- alu_cin  out  1  carry-in to ALU
- alu_y  in  BUS_WIDTH  ALU result
- alu_cout, alu_zero, alu_negative  in  1  ALU flags
- out_valid  out  1  result register holds a result
- out_ready  in  1  writeback accepts result
- out_y  out  BUS_WIDTH  registered result
- out_cout, out_zero, out_negative  out  1  registered per-op flags
- flag_c, flag_z, flag_n  out  1  architectural status register
- ops_retired  out  CNT_WIDTH  count of results accepted downstream

## Operation
- Stage 1 (S1): v1, opcode, a, b, use_carry, flags_we registers. alu_opcode/alu_a/alu_b come directly from the S1 registers. alu_cin = s1_use_carry & flag_c, combinational.
- Stage 2 (S2): out_valid, out_y, out_cout, out_zero, out_negative registers.
- adv2 = v1 & (~out_valid | out_ready): S1 moves to S2. out_* load alu_y/alu_cout/alu_zero/alu_negative and out_valid <= 1.
- out_valid <= 0 when out_ready & out_valid & ~adv2.
- in_ready = ~rst & (~v1 | adv2). This is a combinational path from out_ready.
- in_valid & in_ready: S1 loads in_* and v1 <= 1. Otherwise v1 <= v1 & ~adv2.
- Status register updates on adv2 only, and only if s1_flags_we: flag_c <= alu_cout, flag_z <= alu_zero, flag_n <= alu_negative. If flags_we = 0, the status register holds.
- No carry hazard: an op reaches S1 only after its predecessor left S1. The predecessor's flag update lands on that same edge, so S1 always sees committed flags.
- ops_retired increments on out_valid & out_ready and wraps modulo 2^CNT_WIDTH.
- S1 operands are held stable while v1 & ~adv2. Under backpressure the ALU inputs do not change, and alu_cin stays stable because flags do not update.
- The stage never reorders, drops or duplicates operations.

## Timing
- Reset values: v1, out_valid, out_y, out_cout, out_zero, out_negative, flag_c, flag_z, flag_n, ops_retired and all S1 registers are 0. in_ready is 0 while rst is high and 1 on the first cycle after.
- Latency: an op accepted at edge k gives out_valid = 1 after edge k+1, and the result is presentable in cycle k+1. Throughput is 1 op/cycle when out_ready is held at 1.
- Full: v1 & out_valid & ~out_ready gives in_ready = 0. Two ops are buffered and nothing is lost.
- Simultaneous: out_ready and a new input in the same cycle with both stages full give S2←S1 and S1←in on one edge.
- Reset mid-operation: both in-flight ops are discarded with no downstream handshake. Flags and counter clear.
- Counter wrap: all-ones +1 gives 0 with no flag.

## Test plan
- Reset/idle: assert rst 2 cycles, then release. Every output except in_ready reads 0, and in_ready = 1 on the first cycle after release.
- Single op: accept a=0x0F, b=0x01, flags_we=1, with the bench ALU returning y=0x10, cout=0. Expect out_y=0x10 one edge after acceptance, flag_z=0, and ops_retired=1 after out_ready.
- Carry chain: op1 with the bench returning y=0x00, cout=1, zero=1. Then op2 with use_carry=1 issued back-to-back. Expect alu_cin=1 during op2's S1 cycle, and flag_z=1 after op1.
- flags_we=0: the op's cout=1 appears in out_cout, but flag_c keeps its prior value 0.
- Backpressure: hold out_ready=0 while issuing 3 ops. The third is refused (in_ready=0) and alu_a/alu_b stay stable. Releasing out_ready gives results in order with no loss.
- Reset mid-flight: two ops in flight, then rst for 1 cycle. Expect out_valid=0 and the flags cleared, with no result ever presented.
